// File: rtl/dsa_multich_pkg.sv
// Shared definitions for the multi-channel downscaler: register map, FSM encodings,
// STATUS bit positions and the output-dimension helper.
package dsa_multich_pkg;

   localparam logic [31:0] A_CTRL     = 32'h00;
   localparam logic [31:0] A_STATUS   = 32'h01;
   localparam logic [31:0] A_IMG_W    = 32'h02;
   localparam logic [31:0] A_IMG_H    = 32'h03;
   localparam logic [31:0] A_SCALE    = 32'h04;
   localparam logic [31:0] A_NUM_CH   = 32'h05;
   localparam logic [31:0] A_PERF_CYC = 32'h06;
   localparam logic [31:0] A_PERF_PIX = 32'h07;
   localparam logic [31:0] A_OUT_W    = 32'h08;
   localparam logic [31:0] A_OUT_H    = 32'h09;
   localparam logic [31:0] A_IN_ADDR  = 32'h20;
   localparam logic [31:0] A_IN_DATA  = 32'h21;
   localparam logic [31:0] A_OUT_ADDR = 32'h30;
   localparam logic [31:0] A_OUT_DATA = 32'h31;

   localparam int ST_BUSY  = 0;
   localparam int ST_DONE  = 1;
   localparam int ST_ERR   = 2;
   localparam int ST_ABORT = 3;

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_FIN} seq_state_e;
   typedef enum logic [1:0] {C_IDLE, C_RD, C_WR, C_DONE} core_state_e;

   // Scaled dimension, clamped to [1, min(maxd, dim)].
   function automatic logic [15:0] out_dim(input logic [15:0] dim, input logic [15:0] scale,
                                           input logic [31:0] maxd);
      logic [31:0] p, hi;
      p  = (32'(dim) * 32'(scale)) >> 8;
      hi = (32'(dim) < maxd) ? 32'(dim) : maxd;
      if (p < 32'd1) p = 32'd1;
      else if (p > hi) p = hi;
      return 16'(p);
   endfunction

endpackage

// File: rtl/dsa_top_multich_core.sv
// Scalar bilinear resampler: one output pixel per five cycles (four taps read, one write)
// over a single plane with row stride W_MAX.
module bilinear_core_scalar
   import dsa_multich_pkg::*;
#(
   parameter int W_MAX     = 32,
   parameter int H_MAX     = 32,
   parameter int step_mode = 0,
   parameter int AW        = $clog2(W_MAX * H_MAX) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [15:0]   in_w,
   input  logic [15:0]   in_h,
   input  logic [15:0]   out_w,
   input  logic [15:0]   out_h,
   input  logic [15:0]   inv_scale,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          wr_valid,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          done
);

   core_state_e     state;
   logic [15:0]     ox, oy;
   logic [1:0]      rd_idx;
   logic [3:0][7:0] p;

   logic [31:0] half, off, sx, sy, t, b, acc;
   logic [15:0] xlim, ylim, x0, x1, y0, y1;
   logic [7:0]  fx, fy;

   function automatic logic [AW-1:0] pix_addr(input logic [15:0] y, input logic [15:0] x);
      return AW'(32'(y) * 32'(W_MAX) + 32'(x));
   endfunction

   always_comb begin
      half = {17'b0, inv_scale[15:1]};
      off  = 32'd0;
      // Non-zero step_mode samples pixel centres instead of top-left corners.
      if (step_mode != 0 && half >= 32'd128) off = half - 32'd128;
      sx   = 32'(ox) * 32'(inv_scale) + off;
      sy   = 32'(oy) * 32'(inv_scale) + off;
      xlim = in_w - 16'd1;
      ylim = in_h - 16'd1;
      x0   = (sx[31:8] >= 24'(xlim)) ? xlim : sx[23:8];
      y0   = (sy[31:8] >= 24'(ylim)) ? ylim : sy[23:8];
      x1   = (x0 < xlim) ? x0 + 16'd1 : xlim;
      y1   = (y0 < ylim) ? y0 + 16'd1 : ylim;
      fx   = sx[7:0];
      fy   = sy[7:0];
      case (rd_idx)
         2'd0:    rd_addr = pix_addr(y0, x0);
         2'd1:    rd_addr = pix_addr(y0, x1);
         2'd2:    rd_addr = pix_addr(y1, x0);
         default: rd_addr = pix_addr(y1, x1);
      endcase
      t   = 32'(p[0]) * (32'd256 - 32'(fx)) + 32'(p[1]) * 32'(fx);
      b   = 32'(p[2]) * (32'd256 - 32'(fx)) + 32'(p[3]) * 32'(fx);
      acc = t * (32'd256 - 32'(fy)) + b * 32'(fy) + 32'd32768;
   end

   assign wr_valid = (state == C_WR);
   assign wr_addr  = pix_addr(oy, ox);
   assign wr_data  = 8'(acc >> 16);
   assign done     = (state == C_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= C_IDLE;
         ox     <= '0;
         oy     <= '0;
         rd_idx <= '0;
         p      <= '0;
      end else begin
         case (state)
            C_IDLE: if (start) begin
               ox     <= '0;
               oy     <= '0;
               rd_idx <= '0;
               state  <= C_RD;
            end
            C_RD: begin
               p[rd_idx] <= rd_data;
               rd_idx    <= rd_idx + 2'd1;
               if (rd_idx == 2'd3) state <= C_WR;
            end
            C_WR: begin
               if (ox == out_w - 16'd1) begin
                  ox <= '0;
                  if (oy == out_h - 16'd1) state <= C_DONE;
                  else begin
                     oy    <= oy + 16'd1;
                     state <= C_RD;
                  end
               end else begin
                  ox    <= ox + 16'd1;
                  state <= C_RD;
               end
            end
            default: state <= C_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dsa_top_multich.sv
// Multi-channel downscaler: host CSRs, byte-plane memories and a sequencer that
// time-shares one bilinear core across NUM_CH planes.
module dsa_top_multich
   import dsa_multich_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int IMG_MAX_W  = 32,
   parameter int IMG_MAX_H  = 32,
   parameter int CH_MAX     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  h_wr_en,
   input  logic                  h_rd_en,
   input  logic [ADDR_WIDTH-1:0] h_addr,
   input  logic [31:0]           h_wdata,
   output logic [31:0]           h_rdata,
   output logic                  h_rvalid,
   output logic                  irq
);

   localparam logic [31:0] PLANE = 32'(IMG_MAX_W * IMG_MAX_H);
   localparam int          DEPTH = CH_MAX * IMG_MAX_W * IMG_MAX_H;
   localparam logic [31:0] WORDS = 32'(DEPTH / 4);
   localparam int          MAW   = $clog2(DEPTH);
   localparam int          CAW   = $clog2(IMG_MAX_W * IMG_MAX_H) + 1;

   seq_state_e  state;
   logic [7:0]  ch, num_ch;
   logic        abort_pend, irq_en, done, err, aborted;
   logic [15:0] img_w, img_h, scale, out_w, out_h, inv_scale;
   logic [31:0] perf_cyc, perf_pix, in_addr, out_addr;

   logic [7:0] in_mem  [DEPTH];
   logic [7:0] out_mem [DEPTH];

   logic [31:0]    ha, base, out_word;
   logic           busy, ctrl_wr, st_wr, start_req, abort_req, cfg_bad, in_wr_ok;
   logic           core_start, core_wr_valid, core_done;
   logic [CAW-1:0] core_rd_addr, core_wr_addr;
   logic [7:0]     core_rd_data, core_wr_data;

   assign ha        = 32'(h_addr);
   assign busy      = (state != S_IDLE);
   assign ctrl_wr   = h_wr_en && ha == A_CTRL;
   assign st_wr     = h_wr_en && ha == A_STATUS;
   assign abort_req = ctrl_wr && h_wdata[1];
   assign start_req = ctrl_wr && h_wdata[0] && !h_wdata[1];
   assign cfg_bad   = img_w == 16'd0 || img_h == 16'd0 || num_ch == 8'd0 ||
                      32'(img_w) > 32'(IMG_MAX_W) || 32'(img_h) > 32'(IMG_MAX_H) ||
                      32'(num_ch) > 32'(CH_MAX);
   assign in_wr_ok  = !busy && h_wr_en && ha == A_IN_DATA && in_addr < WORDS - 32'd1;
   assign base      = 32'(ch) * PLANE;
   assign irq       = irq_en & done;
   assign h_rvalid  = h_rd_en;
   assign core_start = (state == S_LAUNCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ch         <= '0;
         abort_pend <= 1'b0;
         irq_en     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         aborted    <= 1'b0;
         img_w      <= '0;
         img_h      <= '0;
         scale      <= '0;
         num_ch     <= '0;
         out_w      <= '0;
         out_h      <= '0;
         inv_scale  <= 16'h0100;
         perf_cyc   <= '0;
         perf_pix   <= '0;
      end else begin
         if (ctrl_wr) irq_en <= h_wdata[2];
         if (!busy && h_wr_en) begin
            if (ha == A_IMG_W)  img_w  <= h_wdata[15:0];
            if (ha == A_IMG_H)  img_h  <= h_wdata[15:0];
            if (ha == A_SCALE)  scale  <= h_wdata[15:0];
            if (ha == A_NUM_CH) num_ch <= h_wdata[7:0];
         end
         // W1C first so that a FIN set later in this block wins the same cycle.
         if (st_wr) begin
            if (h_wdata[ST_DONE])  done    <= 1'b0;
            if (h_wdata[ST_ERR])   err     <= 1'b0;
            if (h_wdata[ST_ABORT]) aborted <= 1'b0;
         end
         if (busy) perf_cyc <= perf_cyc + 32'd1;
         if (core_wr_valid) perf_pix <= perf_pix + 32'd1;
         if (busy && abort_req) abort_pend <= 1'b1;
         case (state)
            S_IDLE: if (start_req) begin
               if (cfg_bad) err <= 1'b1;
               else begin
                  out_w      <= out_dim(img_w, scale, 32'(IMG_MAX_W));
                  out_h      <= out_dim(img_h, scale, 32'(IMG_MAX_H));
                  inv_scale  <= (scale == 16'd0) ? 16'h0100 : 16'(32'h10000 / 32'(scale));
                  done       <= 1'b0;
                  aborted    <= 1'b0;
                  perf_cyc   <= '0;
                  perf_pix   <= '0;
                  ch         <= '0;
                  abort_pend <= 1'b0;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: state <= S_RUN;
            S_RUN:    if (core_done) state <= S_NEXT;
            S_NEXT: begin
               if (abort_pend || abort_req || ch == num_ch - 8'd1) state <= S_FIN;
               else begin
                  ch    <= ch + 8'd1;
                  state <= S_LAUNCH;
               end
            end
            default: begin
               if (abort_pend) aborted <= 1'b1;
               else            done    <= 1'b1;
               abort_pend <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_addr  <= '0;
         out_addr <= '0;
      end else begin
         if (!busy && h_wr_en && ha == A_IN_ADDR) in_addr <= h_wdata;
         if (in_wr_ok) in_addr <= in_addr + 32'd1;
         if (h_wr_en && ha == A_OUT_ADDR) out_addr <= h_wdata;
         if (h_rd_en && ha == A_OUT_DATA && out_addr < WORDS - 32'd1) out_addr <= out_addr + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (in_wr_ok)
         for (int b = 0; b < 4; b++) in_mem[{in_addr[MAW-3:0], 2'(b)}] <= h_wdata[8*b +: 8];
      if (core_wr_valid && 32'(core_wr_addr) < PLANE)
         out_mem[MAW'(base + 32'(core_wr_addr))] <= core_wr_data;
   end

   assign core_rd_data = (32'(core_rd_addr) < PLANE) ? in_mem[MAW'(base + 32'(core_rd_addr))] : 8'h00;
   assign out_word = (out_addr < WORDS) ?
                     {out_mem[{out_addr[MAW-3:0], 2'd3}], out_mem[{out_addr[MAW-3:0], 2'd2}],
                      out_mem[{out_addr[MAW-3:0], 2'd1}], out_mem[{out_addr[MAW-3:0], 2'd0}]} : 32'h0;

   always_comb begin
      h_rdata = 32'h0;
      case (ha)
         A_CTRL:     h_rdata = {29'b0, irq_en, 2'b0};
         A_STATUS:   h_rdata = {28'b0, aborted, err, done, busy};
         A_IMG_W:    h_rdata = 32'(img_w);
         A_IMG_H:    h_rdata = 32'(img_h);
         A_SCALE:    h_rdata = 32'(scale);
         A_NUM_CH:   h_rdata = 32'(num_ch);
         A_PERF_CYC: h_rdata = perf_cyc;
         A_PERF_PIX: h_rdata = perf_pix;
         A_OUT_W:    h_rdata = 32'(out_w);
         A_OUT_H:    h_rdata = 32'(out_h);
         A_IN_ADDR:  h_rdata = in_addr;
         A_OUT_ADDR: h_rdata = out_addr;
         A_OUT_DATA: h_rdata = out_word;
         default:    h_rdata = 32'h0;
      endcase
   end

   bilinear_core_scalar #(.W_MAX(IMG_MAX_W), .H_MAX(IMG_MAX_H), .step_mode(0)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (core_start),
      .in_w      (img_w),
      .in_h      (img_h),
      .out_w     (out_w),
      .out_h     (out_h),
      .inv_scale (inv_scale),
      .rd_addr   (core_rd_addr),
      .rd_data   (core_rd_data),
      .wr_valid  (core_wr_valid),
      .wr_addr   (core_wr_addr),
      .wr_data   (core_wr_data),
      .done      (core_done)
   );

endmodule
